// File: rtl/cnn_pixel_streamer_if.sv
// rtl/cnn_pixel_streamer_if.sv - host write port and pixel stream bundle for cnn_pixel_streamer
interface cnn_pixel_streamer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = 20,
  parameter int IMG_HEIGHT   = 20,
  parameter int NUM_CHANNELS = 3
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int CW   = $clog2(IMG_WIDTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data_ch [NUM_CHANNELS];
  logic                  wr_drop;
  logic                  start;
  logic                  pause;
  logic [DATA_WIDTH-1:0] pixel_out_ch [NUM_CHANNELS];
  logic                  valid_out;
  logic [RW-1:0]         row_out;
  logic [CW-1:0]         col_out;
  logic                  last_out;
  logic                  busy;
  logic                  done;

  modport master (
    output wr_en, wr_addr, wr_data_ch, start, pause,
    input  wr_drop, pixel_out_ch, valid_out, row_out, col_out, last_out, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data_ch, start, pause,
    output wr_drop, pixel_out_ch, valid_out, row_out, col_out, last_out, busy, done
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// rtl/cnn_pixel_streamer.sv - frame buffer that replays a stored image as a raster pixel stream
module cnn_pixel_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = 20,
  parameter int IMG_HEIGHT   = 20,
  parameter int NUM_CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  cnn_pixel_streamer_if.slave   bus
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int PW   = NUM_CHANNELS * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] mem [NPIX];
  logic [PW-1:0] wr_word;
  logic [PW-1:0] rd_word;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          wr_ok;
  logic          issue;
  logic          at_last;

  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          drop_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  always_comb begin
    wr_word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_word[c*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data_ch[c];
    end
  end

  // One extra bit on the compare so a power-of-two NPIX still bounds correctly
  assign wr_ok   = bus.wr_en && (state == IDLE) && ({1'b0, bus.wr_addr} < (AW+1)'(NPIX));
  assign issue   = (state == STREAM) && !bus.pause;
  assign at_last = (rd_ptr == AW'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.wr_addr] <= wr_word;
    end
  end

  // Read register doubles as the output pixel: it only loads on an issued read, so it holds across pauses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word <= '0;
    end else if (issue) begin
      rd_word <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      drop_q  <= bus.wr_en && !wr_ok;
      valid_q <= issue;
      last_q  <= issue && at_last;
      done_q  <= 1'b0;

      if (issue) begin
        row_q <= row_cnt;
        col_q <= col_cnt;
        if (col_cnt == CW'(IMG_WIDTH - 1)) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == RW'(IMG_HEIGHT - 1)) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= STREAM;
            busy_q  <= 1'b1;
            rd_ptr  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
          end
        end
        STREAM: begin
          if (!bus.pause) begin
            if (at_last) begin
              state  <= DRAIN;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign bus.pixel_out_ch[c] = rd_word[c*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wr_drop   = drop_q;
  assign bus.row_out   = row_q;
  assign bus.col_out   = col_q;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// tb/tb_cnn_pixel_streamer.sv - self-checking bench for cnn_pixel_streamer
module tb_cnn_pixel_streamer;
  localparam int DW   = 8;
  localparam int IW   = 20;
  localparam int IH   = 20;
  localparam int NC   = 3;
  localparam int NPIX = IW * IH;

  typedef struct {
    logic        en;
    logic [8:0]  addr;
    logic [23:0] data;
    logic        exp_drop;
  } wr_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_pixel_streamer_if #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .NUM_CHANNELS(NC)) bus ();

  cnn_pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .NUM_CHANNELS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] model_mem [NPIX];
  logic [23:0] held_pix;
  wr_vec_t     vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic ev, input logic el, input logic eb,
                           input logic ed, input logic edrop, input int idx, input logic [23:0] epix);
    logic [4:0]  er, ec, ar, ac;
    logic [63:0] e, a;
    er = ev ? 5'(idx / IW) : 5'd0;
    ec = ev ? 5'(idx % IW) : 5'd0;
    ar = ev ? bus.row_out : 5'd0;
    ac = ev ? bus.col_out : 5'd0;
    e  = {25'd0, ev, el, eb, ed, edrop, er, ec, epix};
    a  = {25'd0, bus.valid_out, bus.last_out, bus.busy, bus.done, bus.wr_drop, ar, ac,
          bus.pixel_out_ch[2], bus.pixel_out_ch[1], bus.pixel_out_ch[0]};
    check(name, a, e);
  endtask

  task automatic set_wr(input logic [8:0] addr, input logic [23:0] data);
    bus.wr_addr = addr;
    for (int c = 0; c < NC; c++) bus.wr_data_ch[c] = data[c*8 +: 8];
  endtask

  // mode 0: no pause, 1: 3 cycles at pixel 57 and 1 at pixel 399, 2: random
  task automatic stream_frame(input int mode, input int wr_at, input int start_at, input bit same_wr);
    int   next_idx, p57, p399, cyc, npaused, issued;
    logic p, in_stream, wr_fired, wrote;
    next_idx = 0; p57 = 0; p399 = 0; npaused = 0; wr_fired = 0;
    bus.start = 1'b1;
    if (same_wr) begin
      bus.wr_en = 1'b1;
      set_wr(9'd0, 24'hAAAAAA);
      model_mem[0] = 24'hAAAAAA;
    end
    tick();
    cyc = 1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check_out("stream_entry", 0, 0, 1, 0, 0, 0, held_pix);
    forever begin
      in_stream = (next_idx < NPIX);
      case (mode)
        1: begin
          p = !in_stream;
          if (in_stream && next_idx == 57 && p57 < 3) begin p = 1'b1; p57++; end
          if (in_stream && next_idx == 399 && p399 < 1) begin p = 1'b1; p399++; end
        end
        2: p = ($urandom_range(0, 3) == 0);
        default: p = 1'b0;
      endcase
      bus.pause = p;
      bus.start = in_stream && (next_idx == start_at);
      wrote = in_stream && (next_idx == wr_at) && !wr_fired;
      bus.wr_en = wrote;
      if (wrote) begin
        wr_fired = 1'b1;
        set_wr(9'd3, 24'hEEEEEE);
      end
      issued = (in_stream && !p) ? next_idx : -1;
      if (in_stream && p) npaused++;
      tick();
      cyc++;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (issued >= 0) begin
        held_pix = model_mem[issued];
        check_out("stream_px", 1, issued == NPIX - 1, 1, 0, wrote, issued, held_pix);
        next_idx++;
      end else if (in_stream) begin
        check_out("stream_pause", 0, 0, 1, 0, wrote, 0, held_pix);
      end else begin
        check_out("done_cycle", 0, 0, 0, 1, 0, 0, held_pix);
        break;
      end
      if (cyc > 3000) begin
        check("stream_timeout", 64'(cyc), 64'(NPIX + 2 + npaused));
        break;
      end
    end
    bus.pause = 1'b0;
    check("done_latency", 64'(cyc), 64'(NPIX + 2 + npaused));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_out("idle_after_done", 0, 0, 0, 0, 0, 0, held_pix);
    tick();
    check_out("start_in_done_ignored", 0, 0, 0, 0, 0, 0, held_pix);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] d;
    vecs[0] = '{1'b1, 9'd400, 24'h123456, 1'b1};
    vecs[1] = '{1'b0, 9'd400, 24'h000000, 1'b0};
    vecs[2] = '{1'b1, 9'd511, 24'hFFFFFF, 1'b1};
    vecs[3] = '{1'b1, 9'd399, 24'h001313, 1'b0};
    vecs[4] = '{1'b1, 9'd20,  24'h010100, 1'b0};
    vecs[5] = '{1'b0, 9'd0,   24'h000000, 1'b0};

    bus.wr_en = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    set_wr(9'd0, 24'd0);
    held_pix = 24'd0;
    rst = 1'b1;
    tick(); tick();
    check_out("reset", 0, 0, 0, 0, 0, 0, 24'd0);
    rst = 1'b0;
    tick();
    check_out("idle_after_reset", 0, 0, 0, 0, 0, 0, 24'd0);

    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        d = {8'(c ^ r), 8'(r), 8'(c)};
        bus.wr_en = 1'b1;
        set_wr(9'(r * IW + c), d);
        model_mem[r * IW + c] = d;
        tick();
      end
    end
    bus.wr_en = 1'b0;
    tick();
    check_out("load_done", 0, 0, 0, 0, 0, 0, held_pix);

    for (int i = 0; i < 6; i++) begin
      bus.wr_en = vecs[i].en;
      set_wr(vecs[i].addr, vecs[i].data);
      if (vecs[i].en && vecs[i].addr < NPIX) model_mem[vecs[i].addr] = vecs[i].data;
      tick();
      check_out($sformatf("wr_vec%0d", i), 0, 0, 0, 0, vecs[i].exp_drop, 0, held_pix);
    end
    bus.wr_en = 1'b0;

    stream_frame(0, -1, -1, 1'b0);
    stream_frame(1, 30, 100, 1'b0);

    for (int i = 0; i < NPIX; i++) begin
      d = 24'($urandom);
      bus.wr_en = 1'b1;
      set_wr(9'(i), d);
      model_mem[i] = d;
      tick();
    end
    bus.wr_en = 1'b0;
    stream_frame(2, int'($urandom_range(0, 399)), int'($urandom_range(0, 399)), 1'b0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (200) tick();
    check_out("pre_reset_px199", 1, 0, 1, 0, 0, 199, model_mem[199]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held_pix = 24'd0;
    check_out("reset_mid_frame", 0, 0, 0, 0, 0, 0, 24'd0);
    tick();
    check_out("idle_after_mid_reset", 0, 0, 0, 0, 0, 0, 24'd0);
    stream_frame(0, -1, -1, 1'b0);

    stream_frame(0, -1, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
